// File: rtl/cla_bist_if.sv
// Adder-under-test bus: operands and carry-in driven by the BIST engine,
// sum and carry-out returned by the adder.
interface cla_bist_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH-1:0] dut_s;
  logic             dut_cout;

  modport master (
    output dut_a, dut_b, dut_cin,
    input  dut_s, dut_cout
  );

  modport slave (
    input  dut_a, dut_b, dut_cin,
    output dut_s, dut_cout
  );
endinterface

// File: rtl/cla_bist.sv
// Exhaustive stimulus/response checker for a registered carry-lookahead adder:
// sweeps every {cin, b, a}, aligns the reference sum to the adder latency and tallies mismatches.
module cla_bist #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  cla_bist_if.master        adder,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [2*WIDTH:0]  first_fail
);
  localparam int IW    = 2 * WIDTH + 1;
  localparam int DEPTH = LATENCY + 1;
  localparam logic [IW-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg;
  logic [2:0]      drain_reg;
  logic            launch, present;
  logic [WIDTH:0]  exp_now;
  logic            mismatch;

  // Alignment pipe: one stage per clk edge between presentation and compare.
  logic            pipe_valid_reg [DEPTH];
  logic [WIDTH:0]  pipe_exp_reg   [DEPTH];
  logic [IW-1:0]   pipe_idx_reg   [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    present    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        present = 1'b1;
        if (idx_reg == LAST_IDX) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_reg == 3'(LATENCY)) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      drain_reg     <= '0;
      adder.dut_a   <= '0;
      adder.dut_b   <= '0;
      adder.dut_cin <= 1'b0;
    end else begin
      if (launch)                              idx_reg <= '0;
      else if (present && idx_reg != LAST_IDX) idx_reg <= idx_reg + 1'b1;
      drain_reg <= (state_reg == DRAIN) ? drain_reg + 3'd1 : 3'd0;
      if (present) begin
        adder.dut_a   <= idx_reg[WIDTH-1:0];
        adder.dut_b   <= idx_reg[2*WIDTH-1:WIDTH];
        adder.dut_cin <= idx_reg[2*WIDTH];
      end
    end
  end

  assign exp_now = {1'b0, idx_reg[WIDTH-1:0]} + {1'b0, idx_reg[2*WIDTH-1:WIDTH]}
                 + {{WIDTH{1'b0}}, idx_reg[2*WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_reg[0] <= 1'b0;
      pipe_exp_reg[0]   <= '0;
      pipe_idx_reg[0]   <= '0;
    end else begin
      pipe_valid_reg[0] <= present;
      pipe_exp_reg[0]   <= exp_now;
      pipe_idx_reg[0]   <= idx_reg;
    end
  end

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_pipe
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_valid_reg[gi] <= 1'b0;
          pipe_exp_reg[gi]   <= '0;
          pipe_idx_reg[gi]   <= '0;
        end else begin
          pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
          pipe_exp_reg[gi]   <= pipe_exp_reg[gi-1];
          pipe_idx_reg[gi]   <= pipe_idx_reg[gi-1];
        end
      end
    end
  endgenerate

  assign mismatch = pipe_valid_reg[DEPTH-1]
                  && ({adder.dut_cout, adder.dut_s} != pipe_exp_reg[DEPTH-1]);

  // err_count doubles as the "no failure seen yet" flag for first_fail capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      first_fail <= '0;
    end else if (launch) begin
      err_count  <= '0;
      first_fail <= '0;
    end else if (mismatch) begin
      if (err_count != 8'hFF) err_count  <= err_count + 8'd1;
      if (err_count == 8'h00) first_fail <= pipe_idx_reg[DEPTH-1];
    end
  end

  assign busy = (state_reg == RUN) || (state_reg == DRAIN);
  assign done = (state_reg == DONE);
  assign pass = done && (err_count == 8'h00);

endmodule

// File: tb/tb_cla_bist.sv
// Bench for cla_bist: a behavioural adder with selectable fault and latency,
// plus a sweep-level model predicting err_count/first_fail/pass.
module tb_cla_bist;
  localparam int WIDTH = 4;
  localparam int LAT   = 1;
  localparam int NVEC  = 1 << (2 * WIDTH + 1);
  localparam int SWEEP = NVEC + LAT + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         busy, done, pass;
  logic [7:0]   err_count;
  logic [8:0]   first_fail;

  int pass_cnt  = 0;
  int check_cnt = 0;

  int fault     = 0;   // 0 none, 1 s[0] stuck 0, 2 cout inverted
  int adder_lat = 1;   // 0 combinational, 1 registered

  cla_bist_if #(.WIDTH(WIDTH)) bus ();

  cla_bist #(.WIDTH(WIDTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .adder      (bus),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test
  logic [4:0] comb_sum, reg_sum;
  always_comb begin
    comb_sum = {1'b0, bus.dut_a} + {1'b0, bus.dut_b} + {4'b0, bus.dut_cin};
    if (fault == 1) comb_sum[0] = 1'b0;
    if (fault == 2) comb_sum[4] = ~comb_sum[4];
  end
  always_ff @(posedge clk) reg_sum <= comb_sum;
  assign {bus.dut_cout, bus.dut_s} = (adder_lat == 1) ? reg_sum : comb_sum;

  // What the adder returns for vector j under a given fault
  function automatic int resp(input int j, input int f);
    int r;
    r = (j & 15) + ((j >> 4) & 15) + ((j >> 8) & 1);
    if (f == 1) r = r & ~1;
    if (f == 2) r = r ^ 16;
    return r;
  endfunction

  // The checker compares vector i against the adder response to the vector
  // that was on the bus d = LAT - adder_lat presentations later (bus holds the last one).
  task automatic model(input int f, input int alat, output int ecnt, output int ff);
    int d, j, ref_sum;
    d = LAT - alat;
    ecnt = 0;
    ff = 0;
    for (int i = 0; i < NVEC; i++) begin
      ref_sum = (i & 15) + ((i >> 4) & 15) + ((i >> 8) & 1);
      j = (i + d > NVEC - 1) ? NVEC - 1 : i + d;
      if (resp(j, f) != ref_sum) begin
        if (ecnt == 0) ff = i;
        if (ecnt < 255) ecnt++;
      end
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(inout int cyc);
    while (cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
      if (done) break;
    end
  endtask

  task automatic sweep_and_check(input string name);
    int cyc, ecnt, ff;
    model(fault, adder_lat, ecnt, ff);
    cyc = 0;
    start_pulse();
    wait_done(cyc);
    check_cnt++;
    if (cyc !== SWEEP) $display("FAIL %s sweep_cycles got=%0d exp=%0d", name, cyc, SWEEP);
    else pass_cnt++;
    check_cnt++;
    if (err_count !== 8'(ecnt)) $display("FAIL %s err_count got=%0d exp=%0d", name, err_count, ecnt);
    else pass_cnt++;
    check_cnt++;
    if (first_fail !== 9'(ff)) $display("FAIL %s first_fail got=%0d exp=%0d", name, first_fail, ff);
    else pass_cnt++;
    check_cnt++;
    if (pass !== (ecnt == 0)) $display("FAIL %s pass got=%0b exp=%0b", name, pass, ecnt == 0);
    else pass_cnt++;
    $display("sweep %s fault=%0d adder_lat=%0d cycles=%0d err=%0d first=%0d pass=%0b",
             name, fault, adder_lat, cyc, err_count, first_fail, pass);
  endtask

  task automatic check_all_zero(input string name);
    check_cnt++;
    if ({busy, done, pass, err_count, first_fail, bus.dut_a, bus.dut_b, bus.dut_cin} !== '0)
      $display("FAIL %s outputs got busy=%0b done=%0b pass=%0b err=%0d first=%0d vec=%0d exp=all zero",
               name, busy, done, pass, err_count, first_fail, {bus.dut_cin, bus.dut_b, bus.dut_a});
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("idle_after_reset");
    $display("reset checked");
  endtask

  task automatic test_clean();
    fault = 0; adder_lat = 1;
    sweep_and_check("clean");
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL clean busy_in_done got=%0b exp=0", busy);
    else pass_cnt++;
  endtask

  task automatic test_stuck_s0();
    fault = 1; adder_lat = 1;
    sweep_and_check("stuck_s0");
    check_cnt++;
    if (err_count !== 8'd255 || first_fail !== 9'd1)
      $display("FAIL stuck_s0 abs got err=%0d first=%0d exp err=255 first=1", err_count, first_fail);
    else pass_cnt++;
  endtask

  task automatic test_cout_inv();
    fault = 2; adder_lat = 1;
    sweep_and_check("cout_inv");
    check_cnt++;
    if (err_count !== 8'd255 || first_fail !== 9'd0)
      $display("FAIL cout_inv abs got err=%0d first=%0d exp err=255 first=0", err_count, first_fail);
    else pass_cnt++;
  endtask

  task automatic test_latency();
    fault = 0; adder_lat = 0;
    sweep_and_check("lat_mismatch");
    check_cnt++;
    if (err_count === 8'd0) $display("FAIL lat_mismatch nonzero got=%0d exp=>0", err_count);
    else pass_cnt++;
    adder_lat = 1;
    sweep_and_check("lat_match");
  endtask

  task automatic test_reset_mid();
    int cyc;
    fault = 0; adder_lat = 1;
    start_pulse();
    cyc = 0;
    while ({bus.dut_cin, bus.dut_b, bus.dut_a} != 9'd200 && cyc < 1000) begin
      @(posedge clk);
      #1 cyc++;
    end
    check_cnt++;
    if ({bus.dut_cin, bus.dut_b, bus.dut_a} !== 9'd200 || busy !== 1'b1)
      $display("FAIL reset_mid reach_200 got vec=%0d busy=%0b exp vec=200 busy=1",
               {bus.dut_cin, bus.dut_b, bus.dut_a}, busy);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_async");
    @(posedge clk);
    #1 check_all_zero("reset_mid_held");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_mid_idle");
    sweep_and_check("after_reset");
  endtask

  task automatic test_back_to_back();
    int cyc, gap;
    fault = 1; adder_lat = 1;
    start_pulse();
    gap = $urandom_range(20, 400);
    cyc = 0;
    repeat (gap) begin
      @(posedge clk);
      #1 cyc++;
    end
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc++;
    wait_done(cyc);
    check_cnt++;
    if (cyc !== SWEEP) $display("FAIL run_start_ignored cycles got=%0d exp=%0d gap=%0d", cyc, SWEEP, gap);
    else pass_cnt++;
    check_cnt++;
    if (err_count !== 8'd255 || pass !== 1'b0)
      $display("FAIL run_start_result got err=%0d pass=%0b exp err=255 pass=0", err_count, pass);
    else pass_cnt++;
    fault = 0;
    repeat ($urandom_range(1, 10)) @(posedge clk);
    start_pulse();
    check_cnt++;
    if (done !== 1'b0 || pass !== 1'b0 || err_count !== 8'd0 || busy !== 1'b1)
      $display("FAIL done_restart_clear got done=%0b pass=%0b err=%0d busy=%0b exp 0/0/0/1",
               done, pass, err_count, busy);
    else pass_cnt++;
    @(posedge clk);
    #1 check_cnt++;
    if ({bus.dut_cin, bus.dut_b, bus.dut_a} !== 9'd0)
      $display("FAIL done_restart_idx0 got=%0d exp=0", {bus.dut_cin, bus.dut_b, bus.dut_a});
    else pass_cnt++;
    cyc = 1;
    wait_done(cyc);
    check_cnt++;
    if (cyc !== SWEEP || pass !== 1'b1)
      $display("FAIL done_restart_sweep got cycles=%0d pass=%0b exp cycles=%0d pass=1", cyc, pass, SWEEP);
    else pass_cnt++;
    $display("back_to_back gap=%0d restart err=%0d pass=%0b", gap, err_count, pass);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      fault = $urandom_range(0, 2);
      adder_lat = $urandom_range(0, 1);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      sweep_and_check("random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_clean();
    test_stuck_s0();
    test_cout_inv();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
